rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Initiator side of the register file write port. Accepts results from two producers (ALU and LSU) over valid/ready handshakes, round-robin arbitrates, and drives the single RF write port through a registered output stage. Also counts retired writebacks, and can optionally forward the pending write onto the RF read data path.

Parameters:
RF_WIDTH, 32, data width of one register
RF_DEPTH, 32, number of registers; address width is $clog2(RF_DEPTH)
CNT_WIDTH, 32, width of the writeback counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle
alu_addr  in  $clog2(RF_DEPTH)  ALU destination register
alu_data  in  RF_WIDTH  ALU result
lsu_valid  in  1  LSU result valid
lsu_ready  out  1  LSU result accepted this cycle
lsu_addr  in  $clog2(RF_DEPTH)  LSU destination register
lsu_data  in  RF_WIDTH  LSU result
wb_stall  in  1  suspend all grants
wr_en  out  1  RF write enable
rd_addr  out  $clog2(RF_DEPTH)  RF write address
data_in  out  RF_WIDTH  RF write data
rs1_addr  in  $clog2(RF_DEPTH)  RF read address 1 (bypass compare)
rs2_addr  in  $clog2(RF_DEPTH)  RF read address 2 (bypass compare)
rs1_data_rf  in  RF_WIDTH  RF read data 1
rs2_data_rf  in  RF_WIDTH  RF read data 2
rs1_data  out  RF_WIDTH  read data 1 to consumers
rs2_data  out  RF_WIDTH  read data 2 to consumers
wb_count  out  CNT_WIDTH  number of RF writes issued

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, rd_addr=0, data_in=0, wb_count=0, round-robin pointer=ALU. The ready outputs are combinational and read 0 while reset is asserted. Reset mid-transfer drops the in-flight write; no partial write is emitted.
- Handshake: a transfer occurs when valid&ready are both high at a rising edge. A source holds valid, addr and data stable until ready. Ready is combinational from the valids, the pointer and wb_stall. Ready never depends on a source's own data.
- Grant rules:
  - wb_stall=1: both ready=0.
  - Exactly one valid: that source is granted.
  - Both valid: the pointer's source is granted. The pointer then flips to the other source.
  - A single-valid grant sets the pointer to the non-granted source.
- Output stage, one-cycle latency. On a grant, at the next edge: wr_en<=1, rd_addr<=addr, data_in<=data. With no grant: wr_en<=0, and rd_addr/data_in hold their values.
- x0 rule: a granted transfer with addr=0 is accepted (ready=1) but produces wr_en=0 and no count increment.
- wb_count increments by 1 on each cycle that wr_en is registered high. It wraps modulo 2^CNT_WIDTH.
- Same destination from both sources in one cycle: they are serialized in arbitration order, so the later grant wins in the RF.
- Sustained throughput: one write per cycle. Back-to-back grants are allowed.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: rs1_data = data_in when wr_en=1, rd_addr==rs1_addr and rs1_addr!=0; otherwise rs1_data = rs1_data_rf. rs2_data follows the same rule with rs2_addr. Both are combinational, so consumers see a write in the same cycle the RF captures it.
- Undefined: rs1_data=rs1_data_rf and rs2_data=rs2_data_rf, unconditionally.

Test Plan:
- Reset then ALU-only transfer: alu_valid=1, addr=2, data=446 for one cycle -> alu_ready=1 that cycle; next cycle wr_en=1, rd_addr=2, data_in=446; wb_count=1.
- Contention: both valid in cycles 0-1 (ALU addr3/data331, LSU addr4/data77), pointer=ALU -> cycle 0 grants ALU, cycle 1 grants LSU. Writes appear as (3,331) then (4,77); wb_count=2.
- x0 drop: lsu_valid=1, addr=0, data=0xDEAD -> lsu_ready=1; wr_en stays 0; wb_count unchanged.
- Stall: wb_stall=1 for 3 cycles with alu_valid=1 -> alu_ready=0, wr_en=0 throughout. The grant occurs on the first cycle after wb_stall falls.
- Async reset mid-stream: rst_n pulled low between edges while wr_en=1 -> wr_en=0 and wb_count=0 immediately, without waiting for a clock edge; pointer=ALU after release.
- WB_BYPASS_EN defined: write (2,446) pending with rs1_addr=2, rs1_data_rf=0 -> rs1_data=446. With rs1_addr=0 -> rs1_data=rs1_data_rf.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
// Bundles the producer result handshakes (ALU, LSU) and the RF write port.
//   master : arbiter view - takes producer results, drives readies and the write port
//   slave  : producer/RF view - drives results, observes readies and the write port
// Parameters must match those of the rf_wb_arbiter instance it is attached to.
interface rf_wb_arbiter_if #(
    parameter int RF_WIDTH = 32,
    parameter int RF_DEPTH = 32
);
    localparam int AW = $clog2(RF_DEPTH);

    logic                alu_valid;
    logic                alu_ready;
    logic [AW-1:0]       alu_addr;
    logic [RF_WIDTH-1:0] alu_data;

    logic                lsu_valid;
    logic                lsu_ready;
    logic [AW-1:0]       lsu_addr;
    logic [RF_WIDTH-1:0] lsu_data;

    logic                wr_en;
    logic [AW-1:0]       rd_addr;
    logic [RF_WIDTH-1:0] data_in;

    modport master (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready,
        output wr_en, rd_addr, data_in
    );

    modport slave (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  alu_ready, lsu_ready,
        input  wr_en, rd_addr, data_in
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Round-robin arbiter between ALU and LSU results feeding the single RF write
// port through a one-cycle registered stage; counts issued writes and can
// forward the pending write onto the RF read data path.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wb                  rf_wb_arbiter_if.master: ALU/LSU handshakes + RF write port
//   wb_stall            suspends all grants
//   rs1/rs2_addr        RF read addresses (bypass compare)
//   rs1/rs2_data_rf     raw RF read data
//   rs1/rs2_data        read data to consumers
//   wb_count            number of RF writes issued (wraps)
// Optional feature macro: WB_BYPASS_EN (forward pending write to rs1/rs2_data).
//
// Pointer FSM:
//   state   | meaning
//   PTR_ALU | ALU wins when both sources are valid
//   PTR_LSU | LSU wins when both sources are valid
module rf_wb_arbiter #(
    parameter int  RF_WIDTH  = 32,
    parameter int  RF_DEPTH  = 32,
    parameter int  CNT_WIDTH = 32,
    localparam int AW        = $clog2(RF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_wb_arbiter_if.master      wb,
    input  logic                 wb_stall,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    input  logic [RF_WIDTH-1:0]  rs1_data_rf,
    input  logic [RF_WIDTH-1:0]  rs2_data_rf,
    output logic [RF_WIDTH-1:0]  rs1_data,
    output logic [RF_WIDTH-1:0]  rs2_data,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic {PTR_ALU, PTR_LSU} ptr_e;

    ptr_e                ptr_q, ptr_d;
    logic                alu_gnt, lsu_gnt;
    logic                gnt_vld;
    logic [AW-1:0]       gnt_addr;
    logic [RF_WIDTH-1:0] gnt_data;

    logic                 wr_en_q;
    logic [AW-1:0]        rd_addr_q;
    logic [RF_WIDTH-1:0]  data_in_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Readies are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        alu_gnt  = 1'b0;
        lsu_gnt  = 1'b0;
        ptr_d    = ptr_q;
        gnt_addr = '0;
        gnt_data = '0;
        if (rst_n && !wb_stall) begin
            if (wb.alu_valid && (!wb.lsu_valid || ptr_q == PTR_ALU)) begin
                alu_gnt  = 1'b1;
                ptr_d    = PTR_LSU;
                gnt_addr = wb.alu_addr;
                gnt_data = wb.alu_data;
            end else if (wb.lsu_valid) begin
                lsu_gnt  = 1'b1;
                ptr_d    = PTR_ALU;
                gnt_addr = wb.lsu_addr;
                gnt_data = wb.lsu_data;
            end
        end
    end

    assign gnt_vld = alu_gnt || lsu_gnt;

    // Writes to x0 are accepted but leave the output stage and counter idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            data_in_q <= '0;
            cnt_q     <= '0;
        end else if (gnt_vld && gnt_addr != '0) begin
            wr_en_q   <= 1'b1;
            rd_addr_q <= gnt_addr;
            data_in_q <= gnt_data;
            cnt_q     <= cnt_q + CNT_WIDTH'(1);
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign wb.alu_ready = alu_gnt;
    assign wb.lsu_ready = lsu_gnt;
    assign wb.wr_en     = wr_en_q;
    assign wb.rd_addr   = rd_addr_q;
    assign wb.data_in   = data_in_q;
    assign wb_count     = cnt_q;

`ifdef WB_BYPASS_EN
    assign rs1_data = (wr_en_q && rd_addr_q == rs1_addr && rs1_addr != '0) ? data_in_q : rs1_data_rf;
    assign rs2_data = (wr_en_q && rd_addr_q == rs2_addr && rs2_addr != '0) ? data_in_q : rs2_data_rf;
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1_addr, rs2_addr};
    assign rs1_data       = rs1_data_rf;
    assign rs2_data       = rs2_data_rf;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int CNT_WIDTH = 32;
    localparam int AW        = $clog2(RF_DEPTH);

    logic                 clk;
    logic                 rst_n;
    logic                 wb_stall;
    logic [AW-1:0]        rs1_addr, rs2_addr;
    logic [RF_WIDTH-1:0]  rs1_data_rf, rs2_data_rf;
    logic [RF_WIDTH-1:0]  rs1_data, rs2_data;
    logic [CNT_WIDTH-1:0] wb_count;

    int checks   = 0;
    int failures = 0;

    rf_wb_arbiter_if #(.RF_WIDTH(RF_WIDTH), .RF_DEPTH(RF_DEPTH)) wb ();

    rf_wb_arbiter #(
        .RF_WIDTH (RF_WIDTH),
        .RF_DEPTH (RF_DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb.master),
        .wb_stall   (wb_stall),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data_rf(rs1_data_rf),
        .rs2_data_rf(rs2_data_rf),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [31:0]   ad;
        logic          lv;
        logic [AW-1:0] la;
        logic [31:0]   ld;
        logic          st;
        logic          e_ar;
        logic          e_lr;
        logic          e_we;
        logic [AW-1:0] e_ra;
        logic [31:0]   e_di;
        logic [31:0]   e_cnt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [31:0] ld,
                         input logic st);
        wb.alu_valid = av;
        wb.alu_addr  = aa;
        wb.alu_data  = ad;
        wb.lsu_valid = lv;
        wb.lsu_addr  = la;
        wb.lsu_data  = ld;
        wb_stall     = st;
    endtask

    initial begin
        logic [31:0] exp_byp;

        //            av aa  ad      lv la ld      st  ar lr we ra di     cnt
        vecs[0]  = '{1, 2, 446,     0, 0, 0,      0,  1, 0, 1, 2, 446,   1};  // ALU only
        vecs[1]  = '{0, 0, 0,       0, 0, 0,      0,  0, 0, 0, 2, 446,   1};  // idle, hold
        vecs[2]  = '{0, 0, 0,       1, 5, 9,      0,  0, 1, 1, 5, 9,     2};  // LSU only -> ptr ALU
        vecs[3]  = '{1, 3, 331,     1, 4, 77,     0,  1, 0, 1, 3, 331,   3};  // contention, ALU first
        vecs[4]  = '{1, 6, 1,       1, 4, 77,     0,  0, 1, 1, 4, 77,    4};  // contention, LSU next
        vecs[5]  = '{1, 6, 1,       0, 0, 0,      0,  1, 0, 1, 6, 1,     5};
        vecs[6]  = '{0, 0, 0,       1, 0, 'hDEAD, 0,  0, 1, 0, 6, 1,     5};  // x0 dropped
        vecs[7]  = '{1, 7, 'h55,    0, 0, 0,      1,  0, 0, 0, 6, 1,     5};  // stall
        vecs[8]  = '{1, 7, 'h55,    0, 0, 0,      1,  0, 0, 0, 6, 1,     5};
        vecs[9]  = '{1, 7, 'h55,    0, 0, 0,      1,  0, 0, 0, 6, 1,     5};
        vecs[10] = '{1, 7, 'h55,    0, 0, 0,      0,  1, 0, 1, 7, 'h55,  6};  // grant after stall
        vecs[11] = '{1, 8, 100,     1, 8, 200,    0,  0, 1, 1, 8, 200,   7};  // same dest, LSU first
        vecs[12] = '{1, 8, 100,     0, 0, 0,      0,  1, 0, 1, 8, 100,   8};  // ALU wins last
        vecs[13] = '{1, 9, 5,       1, 10, 6,     1,  0, 0, 0, 8, 100,   8};  // stall, both valid
        vecs[14] = '{0, 0, 0,       0, 0, 0,      0,  0, 0, 0, 8, 100,   8};

        rst_n       = 1'b0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rs1_data_rf = '0;
        rs2_data_rf = '0;
        drive(1, 2, 446, 1, 3, 1, 0);
        #12;
        chk("rst_wr_en", 64'(wb.wr_en), 64'd0);
        chk("rst_rd_addr", 64'(wb.rd_addr), 64'd0);
        chk("rst_data_in", 64'(wb.data_in), 64'd0);
        chk("rst_wb_count", 64'(wb_count), 64'd0);
        chk("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].st);
            #1;
            chk($sformatf("v%0d_alu_ready", i), 64'(wb.alu_ready), 64'(vecs[i].e_ar));
            chk($sformatf("v%0d_lsu_ready", i), 64'(wb.lsu_ready), 64'(vecs[i].e_lr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i), 64'(wb.wr_en), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_rd_addr", i), 64'(wb.rd_addr), 64'(vecs[i].e_ra));
            chk($sformatf("v%0d_data_in", i), 64'(wb.data_in), 64'(vecs[i].e_di));
            chk($sformatf("v%0d_wb_count", i), 64'(wb_count), 64'(vecs[i].e_cnt));
        end

        // Read-data path: pending write (2,446); pointer is LSU, ALU alone still wins.
        @(negedge clk);
        drive(1, 2, 446, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("byp_wr_en", 64'(wb.wr_en), 64'd1);
        rs1_addr    = 2;
        rs1_data_rf = 0;
        rs2_addr    = 0;
        rs2_data_rf = 'h77;
        #1;
`ifdef WB_BYPASS_EN
        exp_byp = 446;
`else
        exp_byp = 0;
`endif
        chk("byp_rs1_hit", 64'(rs1_data), 64'(exp_byp));
        chk("byp_rs2_x0", 64'(rs2_data), 64'h77);
        rs1_addr    = 0;
        rs1_data_rf = 'h11;
        #1;
        chk("byp_rs1_x0", 64'(rs1_data), 64'h11);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rs1_addr    = 2;
        rs1_data_rf = 'h22;
        #1;
        chk("byp_rs1_idle", 64'(rs1_data), 64'h22);
        chk("byp_count", 64'(wb_count), 64'd9);

        // Async reset while a write is on the port.
        @(negedge clk);
        drive(1, 3, 7, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("ar_pre_wr_en", 64'(wb.wr_en), 64'd1);
        chk("ar_pre_count", 64'(wb_count), 64'd10);
        rst_n = 1'b0;
        #1;
        chk("ar_wr_en", 64'(wb.wr_en), 64'd0);
        chk("ar_count", 64'(wb_count), 64'd0);
        chk("ar_rd_addr", 64'(wb.rd_addr), 64'd0);
        chk("ar_alu_ready", 64'(wb.alu_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3, 7, 1, 4, 8, 0);
        #1;
        chk("ar_ptr_alu_ready", 64'(wb.alu_ready), 64'd1);
        chk("ar_ptr_lsu_ready", 64'(wb.lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ar_post_rd_addr", 64'(wb.rd_addr), 64'd3);
        chk("ar_post_count", 64'(wb_count), 64'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
